// File: rtl/serial_logic_unit_if.sv
// Operand/result bus for serial_logic_unit; carries zero only when SERIAL_LOGIC_ZERO_FLAG_EN is defined.
interface serial_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, op, a, b, input out, busy, done, zero);
  modport slave  (input start, op, a, b, output out, busy, done, zero);
`else
  modport master (output start, op, a, b, input out, busy, done);
  modport slave  (input start, op, a, b, output out, busy, done);
`endif
endinterface

// File: rtl/serial_logic_unit.sv
// Multi-cycle AND/OR/XOR/NOR unit, one SLICE-bit chunk per clock, LSB chunk first.
// Optional registered zero flag enabled by SERIAL_LOGIC_ZERO_FLAG_EN.
module serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst,
  serial_logic_unit_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, out_q;
  logic [WIDTH-1:0] res_nx;
  logic [SLICE-1:0] sa, sb, sres;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  // Slice select and write-back are unrolled muxes so indices stay constant.
  always_comb begin
    sa     = '0;
    sb     = '0;
    res_nx = res_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        sa = a_q[k*SLICE +: SLICE];
        sb = b_q[k*SLICE +: SLICE];
      end
    end
    case (op_q)
      2'b00:   sres = sa & sb;
      2'b01:   sres = sa | sb;
      2'b10:   sres = sa ^ sb;
      default: sres = ~(sa | sb);
    endcase
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt == CW'(k)) res_nx[k*SLICE +: SLICE] = sres;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= bus.op;
            cnt  <= '0;
          end
        end
        BUSY: begin
          res_q <= res_nx;
          cnt   <= cnt + CW'(1);
          if (last) out_q <= res_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst)                        zero_q <= 1'b1;
    else if (state == BUSY && last) zero_q <= (res_nx == '0);
  end

  assign bus.zero = zero_q;
`endif

  assign bus.out  = out_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_logic_unit.sv
// Randomized and directed bench for serial_logic_unit over three WIDTH/SLICE configurations.
module tb_serial_logic_unit;
  logic        clk;
  logic        rst;
  logic        start_s;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s;
  logic        chk_on;
  logic        done_v [3];
  logic        busy_v [3];

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instance 0: 32/8 (N=4), instance 1: 32/32 (N=1), instance 2: 16/4 (N=4).
  for (genvar gi = 0; gi < 3; gi++) begin : cfg
    localparam int W = (gi == 2) ? 16 : 32;
    localparam int S = (gi == 0) ? 8 : ((gi == 1) ? 32 : 4);
    localparam int N = W / S;

    serial_logic_unit_if #(.WIDTH(W)) bus ();

    serial_logic_unit #(.WIDTH(W), .SLICE(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.start  = start_s;
    assign bus.op     = op_s;
    assign bus.a      = a_s[W-1:0];
    assign bus.b      = b_s[W-1:0];
    assign done_v[gi] = bus.done;
    assign busy_v[gi] = bus.busy;

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
        2'b00:   return x & y;
        2'b01:   return x | y;
        2'b10:   return x ^ y;
        default: return ~(x | y);
      endcase
    endfunction

    // ph: edges since acceptance, -1 when idle.
    int           ph     = -1;
    logic [W-1:0] pend   = '0;
    logic [W-1:0] m_out  = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        ph <= -1; m_out <= '0; m_busy <= 1'b0; m_done <= 1'b0;
      end else if (ph < 0) begin
        m_done <= 1'b0;
        if (start_s) begin
          pend   <= ref_op(op_s, a_s[W-1:0], b_s[W-1:0]);
          ph     <= 0;
          m_busy <= 1'b1;
        end
      end else if (ph + 1 == N) begin
        ph <= N; m_out <= pend; m_done <= 1'b1;
      end else if (ph == N) begin
        ph <= -1; m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
        ph <= ph + 1;
      end
    end

    always begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        chk($sformatf("out[%0d]", gi), 64'(bus.out), 64'(m_out));
        chk($sformatf("busy[%0d]", gi), 64'(bus.busy), 64'(m_busy));
        chk($sformatf("done[%0d]", gi), 64'(bus.done), 64'(m_done));
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk($sformatf("zero[%0d]", gi), 64'(bus.zero), 64'(m_out == '0));
`endif
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp, input string nm);
    int lat [3];
    int bcnt;
    @(negedge clk);
    start_s = 1'b1; op_s = o; a_s = av; b_s = bv;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    lat  = '{-1, -1, -1};
    bcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (busy_v[0]) bcnt++;
      for (int k = 0; k < 3; k++) if (done_v[k] && lat[k] < 0) lat[k] = c;
    end
    chk({nm, "_lat0"}, 64'(lat[0]), 64'd4);
    chk({nm, "_lat1"}, 64'(lat[1]), 64'd1);
    chk({nm, "_lat2"}, 64'(lat[2]), 64'd4);
    chk({nm, "_busycycles"}, 64'(bcnt), 64'd5);
    chk({nm, "_out"}, 64'(cfg[0].bus.out), 64'(exp));
  endtask

  initial begin
    int dcount;
    bit seen;
    rst = 1'b1; start_s = 1'b0; op_s = 2'b00; a_s = '0; b_s = '0; chk_on = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_out", 64'(cfg[0].bus.out), 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_done", 64'(done_v[0]), 64'd0);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, "and_ff");
    run_op(2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "and_1");
    run_op(2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "or_1");
    run_op(2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "xor_1");
    run_op(2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "nor_1");
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    chk("nor_zero", 64'(cfg[0].bus.zero), 64'd1);
`endif
    run_op(2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "or_prev");

    // Operands, op and start churn while busy; exactly one done expected.
    @(negedge clk);
    start_s = 1'b1; op_s = 2'b00; a_s = 32'h1000_0001; b_s = 32'h1000_0000;
    @(posedge clk);
    dcount = 0; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        dcount++; seen = 1'b1;
      end else begin
        chk("hold_out", 64'(cfg[0].bus.out), 64'hFFFF_FFFF);
      end
      start_s = 1'($urandom); op_s = 2'($urandom); a_s = $urandom; b_s = $urandom;
    end
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk("immune_done_count", 64'(dcount), 64'd1);
    chk("immune_out", 64'(cfg[0].bus.out), 64'h1000_0000);

    // Reset in the second busy cycle discards the operation.
    @(negedge clk);
    start_s = 1'b1; op_s = 2'b10; a_s = 32'hCAFE_BABE; b_s = 32'h0F0F_0F0F;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", 64'(cfg[0].bus.out), 64'd0);
    chk("midrst_busy", 64'(busy_v[0]), 64'd0);
    chk("midrst_done", 64'(done_v[0]), 64'd0);
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk("midrst_no_done", 64'(dcount), 64'd0);
    run_op(2'b10, 32'hCAFE_BABE, 32'h0F0F_0F0F, 32'hC5F1_B5B1, "after_rst");

    // rst and start on the same edge.
    @(negedge clk);
    rst = 1'b1; start_s = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_s = 1'b0;
    chk("rst_start_busy", 64'(busy_v[0]), 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy_v[0]), 64'd0);

    // Isolated random operations.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start_s = 1'b1; op_s = 2'($urandom); a_s = $urandom; b_s = $urandom;
      @(negedge clk);
      start_s = 1'b0;
      repeat (6) @(negedge clk);
    end

    // Back-to-back traffic with start held high and occasional resets.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start_s = 1'b1; op_s = 2'($urandom); a_s = $urandom; b_s = $urandom;
      rst = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start_s = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
